phase_checker: RTL and testbench
================================

Name: phase_checker

Overview:
- Receive-side counterpart of the board's two-phase blink generator.
- Watches a 1-bit phase signal (1 = phase B, 0 = phase A) and measures each run length in clk_2 cycles.
- Checks each run against the expected A/B lengths, reports lock, errors and a count of good periods on LEDs/LCD.
- Input is synchronous to clk_2 (on-board loopback from the generator or a switch); no synchronizer inside.

Parameters:
- LEN_A, 4: required low-run length in cycles (>=1).
- LEN_B, 3: required high-run length in cycles (>=1).
- CNT_W, 4: run-counter width; must satisfy 2^CNT_W-1 >= max(LEN_A,LEN_B)+1.
- GOOD_W, 8: good-period counter width.

Ports:
- clk_2  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_b  in  1  observed phase signal.
- clear  in  1  synchronous clear of good_count and err_sticky.
- locked  out  1  at least one full correct period since the last error or reset.
- err  out  1  one-cycle error pulse.
- err_sticky  out  1  set by any err; cleared only by clear or reset.
- good_count  out  GOOD_W  number of correct periods, wraps modulo 2^GOOD_W.
- last_len  out  CNT_W  length of the most recently completed run.
- state  out  2  FSM state: SEARCH=0, IN_A=1, IN_B=2; 3 is unused.

Behaviour:
- Reset (reset=0, asynchronous): all registers take these values at once, without waiting for a clock edge.
  - state=SEARCH; outputs locked, err, err_sticky, good_count, last_len all 0.
  - Internal lvl_q=0, run_q=0, a_ok=0.
- Sampling:
  - lvl_q holds the previous in_b sample; run_q counts the cycles lvl_q has held its value.
  - edge = (in_b != lvl_q). The completed run length at an edge is run_q.
  - On edge: lvl_q<=in_b, run_q<=1, last_len<=run_q.
  - Otherwise: run_q<=run_q+1, saturating at all-ones.
- SEARCH:
  - No length checks and no timeout.
  - On edge: go to IN_B if in_b=1, IN_A if in_b=0; a_ok<=0.
  - The run that ended at this edge is never judged.
- IN_A, on a rising edge:
  - run_q==LEN_A: a_ok<=1, go to IN_B.
  - Otherwise: err, a_ok<=0, locked<=0, go to IN_B. Resync on this edge.
- IN_B, on a falling edge:
  - run_q==LEN_B and a_ok=1: good_count+1, locked<=1.
  - run_q==LEN_B and a_ok=0: nothing counted.
  - Wrong length: err, locked<=0.
  - All cases: a_ok<=0, go to IN_A.
- Timeout:
  - Trigger: in IN_A with no edge and run_q>=LEN_A, or in IN_B with no edge and run_q>=LEN_B (the current sample would exceed the expected length).
  - Action: err, locked<=0, a_ok<=0, go to SEARCH.
- Output timing:
  - err is a registered pulse, high for exactly the one cycle following the detecting edge.
  - err_sticky and locked update on the same edge as err.
- clear:
  - Zeroes good_count and err_sticky.
  - clear wins over a simultaneous increment or error.
  - err, locked and the FSM are unaffected.
- good_count wraps from all-ones to 0 without flagging.
- Reset asserted mid-run: immediate return to the reset values; the first edge after release is handled from SEARCH.

Test Plan:
1. Reset, hold in_b=0 for 20 cycles -> state=0, err never asserted, locked=0, good_count=0.
2. After reset, drive 5 periods of 0000111 then 0 (defaults) -> first rise enters IN_B unchecked.
   - good_count increments at falls ending high runs 2..5, final value 4.
   - locked=1 from the first increment; last_len=3; err never asserted.
3. While locked, send a low run of 3 -> err high for one cycle after the rise, locked=0, err_sticky=1, last_len=3, state=2.
   - Next correct B then A then B -> good_count+1, locked=1.
4. While in IN_B, hold in_b=1 for 6 cycles -> err pulse after the 4th high sample, state=0.
   - Next fall enters IN_A with no error.
5. Pulse clear on the same cycle a correct period completes -> good_count=0, err_sticky=0, locked=1.
6. Drop reset mid IN_B with good_count=4 -> all outputs 0 before the next clk_2 edge.
   - After release, pattern 2 repeats identically.

Source files
------------

// File: rtl/phase_checker.sv
// Receive-side checker for the two-phase blink pattern: measures each phase run
// on in_b and reports lock, error pulses and the number of good A/B periods.
module phase_checker #(
   parameter int LEN_A  = 4,
   parameter int LEN_B  = 3,
   parameter int CNT_W  = 4,
   parameter int GOOD_W = 8
) (
   input  logic              clk_2,
   input  logic              reset,
   input  logic              in_b,
   input  logic              clear,
   output logic              locked,
   output logic              err,
   output logic              err_sticky,
   output logic [GOOD_W-1:0] good_count,
   output logic [CNT_W-1:0]  last_len,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      IN_A   = 2'd1,
      IN_B   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LEN_A_C = CNT_W'(LEN_A);
   localparam logic [CNT_W-1:0] LEN_B_C = CNT_W'(LEN_B);

   state_t            state_q;
   logic              lvl_q;
   logic [CNT_W-1:0]  run_q;
   logic              a_ok;

   logic edge_det;
   logic a_len_ok;
   logic b_len_ok;
   logic a_over;
   logic b_over;
   logic err_set;
   logic good_inc;

   assign edge_det = in_b ^ lvl_q;
   assign state    = state_q;

   // An "over" condition means the sample now arriving would stretch the run past its length.
   always_comb begin
      a_len_ok = (run_q == LEN_A_C);
      b_len_ok = (run_q == LEN_B_C);
      a_over   = !edge_det && (run_q >= LEN_A_C);
      b_over   = !edge_det && (run_q >= LEN_B_C);
      err_set  = 1'b0;
      good_inc = 1'b0;
      if (state_q == IN_A)
         err_set = edge_det ? !a_len_ok : a_over;
      else if (state_q == IN_B) begin
         err_set  = edge_det ? !b_len_ok : b_over;
         good_inc = edge_det && b_len_ok && a_ok;
      end
   end

   always_ff @(posedge clk_2 or negedge reset) begin
      if (!reset) begin
         state_q    <= SEARCH;
         lvl_q      <= 1'b0;
         run_q      <= '0;
         a_ok       <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         good_count <= '0;
         last_len   <= '0;
      end else begin
         if (edge_det) begin
            lvl_q    <= in_b;
            run_q    <= CNT_W'(1);
            last_len <= run_q;
         end else if (run_q != {CNT_W{1'b1}}) begin
            run_q <= run_q + CNT_W'(1);
         end

         err <= err_set;
         if (err_set)
            locked <= 1'b0;
         else if (good_inc)
            locked <= 1'b1;

         // clear takes priority over a coincident error or count
         if (clear) begin
            err_sticky <= 1'b0;
            good_count <= '0;
         end else begin
            if (err_set)
               err_sticky <= 1'b1;
            if (good_inc)
               good_count <= good_count + GOOD_W'(1);
         end

         case (state_q)
            SEARCH: begin
               if (edge_det) begin
                  state_q <= in_b ? IN_B : IN_A;
                  a_ok    <= 1'b0;
               end
            end
            IN_A: begin
               if (edge_det) begin
                  a_ok    <= a_len_ok;
                  state_q <= IN_B;
               end else if (a_over) begin
                  a_ok    <= 1'b0;
                  state_q <= SEARCH;
               end
            end
            IN_B: begin
               if (edge_det) begin
                  a_ok    <= 1'b0;
                  state_q <= IN_A;
               end else if (b_over) begin
                  a_ok    <= 1'b0;
                  state_q <= SEARCH;
               end
            end
            default: begin
               a_ok    <= 1'b0;
               state_q <= SEARCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_checker.sv
// Self-checking bench for phase_checker: a run-length table, hand-written corner
// sequences and random runs compared against a run-length reference model.
module tb_phase_checker;

   localparam int LEN_A  = 4;
   localparam int LEN_B  = 3;
   localparam int CNT_W  = 4;
   localparam int GOOD_W = 8;
   localparam int RUN_MAX  = (1 << CNT_W) - 1;
   localparam int GOOD_MOD = 1 << GOOD_W;

   logic              clk_2;
   logic              reset;
   logic              in_b;
   logic              clear;
   logic              locked;
   logic              err;
   logic              err_sticky;
   logic [GOOD_W-1:0] good_count;
   logic [CNT_W-1:0]  last_len;
   logic [1:0]        state;

   int checks = 0;
   int errors = 0;

   phase_checker #(.LEN_A(LEN_A), .LEN_B(LEN_B), .CNT_W(CNT_W), .GOOD_W(GOOD_W)) dut (
      .clk_2(clk_2), .reset(reset), .in_b(in_b), .clear(clear),
      .locked(locked), .err(err), .err_sticky(err_sticky),
      .good_count(good_count), .last_len(last_len), .state(state)
   );

   initial clk_2 = 1'b0;
   always #5 clk_2 = ~clk_2;

   // Reference model: tracks run lengths as plain integers and which phase is due next.
   bit m_lvl, m_aok, m_lock, m_err, m_sticky;
   int m_run, m_mode, m_good, m_last;

   function automatic void modelReset();
      m_lvl = 0; m_aok = 0; m_lock = 0; m_err = 0; m_sticky = 0;
      m_run = 0; m_mode = 0; m_good = 0; m_last = 0;
   endfunction

   function automatic void modelStep(bit b, bit c);
      bit chg = (b != m_lvl);
      bit bad = 0;
      bit inc = 0;
      int want = (m_mode == 1) ? LEN_A : LEN_B;
      if (m_mode == 0) begin
         if (chg) begin m_mode = b ? 2 : 1; m_aok = 0; end
      end else if (chg) begin
         if (m_run != want) bad = 1;
         else if (m_mode == 2 && m_aok) inc = 1;
         m_aok  = (m_mode == 1) && (m_run == want);
         m_mode = (m_mode == 1) ? 2 : 1;
      end else if (m_run + 1 > want) begin
         bad = 1; m_aok = 0; m_mode = 0;
      end
      if (bad) m_lock = 0;
      else if (inc) m_lock = 1;
      m_err = bad;
      if (c) begin m_good = 0; m_sticky = 0; end
      else begin
         if (inc) m_good = (m_good + 1) % GOOD_MOD;
         if (bad) m_sticky = 1;
      end
      if (chg) begin
         m_last = (m_run > RUN_MAX) ? RUN_MAX : m_run;
         m_run = 1; m_lvl = b;
      end else m_run++;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic checkOutput();
      check("state", int'(state), m_mode);
      check("err", int'(err), int'(m_err));
      check("locked", int'(locked), int'(m_lock));
      check("err_sticky", int'(err_sticky), int'(m_sticky));
      check("good_count", int'(good_count), m_good);
      check("last_len", int'(last_len), m_last);
   endtask

   task automatic applyStimulus(input bit b, input bit c);
      @(negedge clk_2);
      in_b = b;
      clear = c;
      @(posedge clk_2);
      modelStep(b, c);
      #1;
      checkOutput();
   endtask

   task automatic doReset();
      @(posedge clk_2);
      #2;
      reset = 1'b0;
      in_b = 1'b0;
      clear = 1'b0;
      #1;
      modelReset();
      check("rst_state", int'(state), 0);
      check("rst_err", int'(err), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_sticky", int'(err_sticky), 0);
      check("rst_good", int'(good_count), 0);
      check("rst_last_len", int'(last_len), 0);
      repeat (2) @(posedge clk_2);
      #2;
      reset = 1'b1;
   endtask

   // Each row is one run; expectations describe the outputs after its first sample.
   typedef struct {
      bit lvl; int len; int st; bit lk; bit e; bit sticky; int good; int ll;
   } row_t;
   row_t tbl[17];

   task automatic runTable(input int first, input int last);
      for (int r = first; r <= last; r++) begin
         for (int k = 0; k < tbl[r].len; k++) begin
            applyStimulus(tbl[r].lvl, 1'b0);
            if (k == 0) begin
               check("tbl_state", int'(state), tbl[r].st);
               check("tbl_locked", int'(locked), int'(tbl[r].lk));
               check("tbl_err", int'(err), int'(tbl[r].e));
               check("tbl_sticky", int'(err_sticky), int'(tbl[r].sticky));
               check("tbl_good", int'(good_count), tbl[r].good);
               check("tbl_last_len", int'(last_len), tbl[r].ll);
            end else begin
               check("tbl_mid_err", int'(err), 0);
               check("tbl_mid_state", int'(state), tbl[r].st);
            end
         end
      end
   endtask

   initial begin
      tbl[0]  = '{0, 4, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 3, 2, 0, 0, 0, 0, 4};
      tbl[2]  = '{0, 4, 1, 0, 0, 0, 0, 3};
      tbl[3]  = '{1, 3, 2, 0, 0, 0, 0, 4};
      tbl[4]  = '{0, 4, 1, 1, 0, 0, 1, 3};
      tbl[5]  = '{1, 3, 2, 1, 0, 0, 1, 4};
      tbl[6]  = '{0, 4, 1, 1, 0, 0, 2, 3};
      tbl[7]  = '{1, 3, 2, 1, 0, 0, 2, 4};
      tbl[8]  = '{0, 4, 1, 1, 0, 0, 3, 3};
      tbl[9]  = '{1, 3, 2, 1, 0, 0, 3, 4};
      tbl[10] = '{0, 3, 1, 1, 0, 0, 4, 3};
      tbl[11] = '{1, 3, 2, 0, 1, 1, 4, 3};
      tbl[12] = '{0, 4, 1, 0, 0, 1, 4, 3};
      tbl[13] = '{1, 3, 2, 0, 0, 1, 4, 4};
      tbl[14] = '{0, 4, 1, 1, 0, 1, 5, 3};
      tbl[15] = '{1, 3, 2, 1, 0, 1, 5, 4};
      tbl[16] = '{0, 1, 1, 1, 0, 1, 6, 3};

      reset = 1'b0;
      in_b = 1'b0;
      clear = 1'b0;
      modelReset();
      #12;
      doReset();

      // Idle low input never leaves SEARCH.
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
      check("idle_state", int'(state), 0);
      check("idle_good", int'(good_count), 0);

      doReset();
      runTable(0, 16);

      // Over-long high run times out after its fourth sample; next fall enters IN_A.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b1, 1'b0);
         if (i >= 4) begin
            check("tmo_err", int'(err), (i == 4) ? 1 : 0);
            check("tmo_state", int'(state), 0);
         end
      end
      applyStimulus(1'b0, 1'b0);
      check("tmo_resync_state", int'(state), 1);
      check("tmo_resync_err", int'(err), 0);

      // Clear on the very cycle a good period completes.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1);
      check("clr_good", int'(good_count), 0);
      check("clr_sticky", int'(err_sticky), 0);
      check("clr_locked", int'(locked), 1);

      // good_count wraps silently.
      for (int p = 1; p <= GOOD_MOD; p++) begin
         for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
         for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
         applyStimulus(1'b0, 1'b0);
         if (p >= GOOD_MOD - 1)
            check("wrap_good", int'(good_count), p % GOOD_MOD);
      end
      check("wrap_err", int'(err_sticky), 0);

      // Asynchronous reset in the middle of a high run, then the pattern repeats.
      doReset();
      runTable(0, 10);
      applyStimulus(1'b1, 1'b0);
      check("pre_rst_good", int'(good_count), 4);
      check("pre_rst_state", int'(state), 2);
      doReset();
      runTable(0, 10);

      // Random runs, mostly of the right length, with occasional clears.
      begin
         bit lvl = 1'b1;
         int cyc = 0;
         while (cyc < 3000) begin
            int want = lvl ? LEN_B : LEN_A;
            int len;
            int pick = $urandom_range(0, 9);
            if (pick < 6) len = want;
            else if (pick < 8) len = want + ($urandom_range(0, 1) ? 1 : -1);
            else len = $urandom_range(1, 9);
            if (len < 1) len = 1;
            for (int k = 0; k < len; k++) begin
               applyStimulus(lvl, ($urandom_range(0, 15) == 0));
               cyc++;
            end
            lvl = ~lvl;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
